decoder_5to32_strobe: RTL
=========================

// Module: decoder_5to32_strobe
// PURPOSE
//  Inverse of the datapath register-select encoder: takes a 5-bit select code and
//  drives one bit of a 32-bit one-hot strobe bus (Rin/Rout style enables) for a fixed
//  number of cycles, then a forced all-zero gap. The gap stops two strobes from
//  overlapping on the shared bus. Sits between control-unit sequencing and the
//  register file / bus mux. Accepts one request at a time with a valid/ready handshake.
// PARAMETERS
//  HOLD_CYCLES  1   cycles the one-hot strobe stays asserted per request (>=1)
//  GAP_CYCLES   1   all-zero cycles forced after each strobe before next accept (>=0)
//  NULL_CODE    31  code meaning "no selection"; handshake completes, bus stays zero
// PORTS
//  clock         in   1   single clock; all state updates on rising edge
//  clear         in   1   synchronous, active-high reset
//  req_valid     in   1   request present on req_code
//  req_code      in   5   register select code 0..31
//  req_ready     out  1   block can accept; high only in IDLE
//  dec_out       out  32  one-hot strobe bus, registered
//  strobe_active out  1   high while in DRIVE (including NULL_CODE requests)
//  null_seen     out  1   high in DRIVE when the latched code == NULL_CODE
//  done          out  1   one-cycle pulse on the last DRIVE cycle
// BEHAVIOUR
//  - Reset (clear=1 at an edge): state=IDLE, dec_out=0, strobe_active=0, null_seen=0,
//    done=0, counters=0. req_ready=1 from the cycle after clear deasserts.
//  - Clear overrides every other event in the same cycle. Clear mid-DRIVE or mid-GAP
//    aborts immediately: dec_out=0 after that edge and no done pulse.
//  - States: IDLE, DRIVE, GAP. All outputs registered except req_ready=(state==IDLE).
//  - IDLE: on an edge with req_valid & req_ready, latch req_code, go to DRIVE and load
//    the counter with HOLD_CYCLES-1. dec_out = (code==NULL_CODE) ? 0 : 32'b1<<code.
//    Latency: accept at edge k means the strobe is visible from edge k through edge
//    k+HOLD_CYCLES.
//  - DRIVE: dec_out holds. req_code/req_valid are ignored. done=1 when counter==0.
//    - Next, with GAP_CYCLES>0: GAP, dec_out=0, counter=GAP_CYCLES-1.
//    - Next, with GAP_CYCLES==0: IDLE, dec_out=0.
//  - GAP: dec_out=0, req_ready=0. Counter decrements. When counter==0, next state is IDLE.
//  - Throughput: one request per HOLD_CYCLES+GAP_CYCLES+1 cycles. The IDLE cycle is
//    needed for the handshake.
//  - At most one bit of dec_out is ever high. dec_out is never nonzero outside DRIVE.
//  - Code 0 drives bit 0 and code 30 drives bit 30. Code 31 with NULL_CODE=31 is a null
//    request. If NULL_CODE is set elsewhere, code 31 drives bit 31.
//  - Counter width = max(1,$clog2(max(HOLD_CYCLES,GAP_CYCLES))). No wrap is possible:
//    the counter only reloads on state entry and stops at 0.
//  - req_valid held high while req_ready=0 is not lost. The request is taken at the
//    next IDLE edge with the code present at that edge.
// TESTING
//  1. clear=1 for 2 cycles, then release -> dec_out=0, done=0, req_ready=1 on the
//     first cycle after release.
//  2. HOLD=1, GAP=1, code=5'd4 accepted -> dec_out=32'h00000010 for exactly 1 cycle
//     with done=1, then 0 for 1 cycle (GAP), then req_ready=1.
//  3. HOLD=3, code=5'd23, req_code changed to 5'd2 during DRIVE -> dec_out stays
//     32'h00800000 for 3 cycles; done only on the 3rd.
//  4. code=5'd31 (NULL_CODE) -> dec_out=0 throughout, strobe_active=1, null_seen=1,
//     done pulse after HOLD_CYCLES.
//  5. Back-to-back: req_valid held high, codes 0 then 1 -> 32'h1, gap 0, idle, 32'h2;
//     strobes never overlap and never touch.
//  6. clear=1 on the 2nd DRIVE cycle (HOLD=4, code 9) -> dec_out=0 and state IDLE
//     next cycle, no done; the next request runs normally.

Source files
------------

// File: rtl/decoder_5to32_strobe_if.sv
// Request handshake and strobe bus between control sequencing and the 5-to-32 strobe decoder.
interface decoder_5to32_strobe_if;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned BUS_W  = 32;

    logic              req_valid;
    logic [CODE_W-1:0] req_code;
    logic              req_ready;
    logic [BUS_W-1:0]  dec_out;
    logic              strobe_active;
    logic              null_seen;
    logic              done;

    modport master (
        output req_valid, req_code,
        input  req_ready, dec_out, strobe_active, null_seen, done
    );

    modport slave (
        input  req_valid, req_code,
        output req_ready, dec_out, strobe_active, null_seen, done
    );
endinterface

// File: rtl/decoder_5to32_strobe.sv
// Drives a one-hot register strobe for HOLD_CYCLES per request, then forces GAP_CYCLES
// of all-zero bus so consecutive strobes can never overlap or touch.
module decoder_5to32_strobe #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned NULL_CODE   = 31
) (
    input  logic                    clock,
    input  logic                    clear,
    decoder_5to32_strobe_if.slave   bus
);
    localparam int unsigned BUS_W   = 32;
    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC <= 1) ? 1 : $clog2(MAX_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUS_W-1:0]   dec_q, dec_d;
    logic               active_q, active_d;
    logic               null_q, null_d;
    logic               done_q, done_d;
    logic               is_null_c;

    assign is_null_c = (32'(bus.req_code) == NULL_CODE);

    // Next-state and next-output logic; outputs fall to zero unless a branch keeps them.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dec_d    = '0;
        active_d = 1'b0;
        null_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d  = S_DRIVE;
                    cnt_d    = CNT_W'(HOLD_CYCLES - 1);
                    dec_d    = is_null_c ? '0 : (BUS_W'(1) << bus.req_code);
                    active_d = 1'b1;
                    null_d   = is_null_c;
                    done_d   = (HOLD_CYCLES == 1);
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    dec_d    = dec_q;
                    active_d = 1'b1;
                    null_d   = null_q;
                    done_d   = (cnt_q == CNT_W'(1));
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; clear wins over everything, aborting any strobe.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dec_q    <= '0;
            active_q <= 1'b0;
            null_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            active_q <= active_d;
            null_q   <= null_d;
            done_q   <= done_d;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.dec_out       = dec_q;
    assign bus.strobe_active = active_q;
    assign bus.null_seen     = null_q;
    assign bus.done          = done_q;
endmodule
